// File: rtl/bcd_serial_add_ctl.sv
// rtl/bcd_serial_add_ctl.sv - digit-serial packed-BCD adder sequencer sharing one external digit adder
module bcd_serial_add_ctl #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a_in,
    input  logic [4*NDIGITS-1:0]   b_in,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   sum_out,
    output logic                   cout,
    output logic                   err,
    output logic                   dig_valid,
    output logic [3:0]             dig_a,
    output logic [3:0]             dig_b,
    output logic                   dig_cin,
    input  logic [3:0]             dig_sum,
    input  logic                   dig_cout
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_sr_q, b_sr_q, acc_q, sum_q;
    logic [W-1:0]    a_sr_d, b_sr_d, acc_d;
    logic [CW-1:0]   cnt_q;
    logic            carry_q, cout_q, err_q, done_q, busy_q, dig_valid_q;
    logic            illegal;

    // Flag any captured digit outside 0..9 in either operand
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((a_sr_q[4*i +: 4] > 4'd9) || (b_sr_q[4*i +: 4] > 4'd9)) begin
                illegal = 1'b1;
            end
        end
    end

    // Next values of the operand shifters and the accumulator during ADD
    always_comb begin
        a_sr_d = a_sr_q >> 4;
        b_sr_d = b_sr_q >> 4;
        acc_d  = (acc_q >> 4) | (W'(dig_sum) << (W - 4));
    end

    // Control FSM with registered status outputs and the serial datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dig_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr_q  <= a_in;
                        b_sr_q  <= b_in;
                        carry_q <= cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (illegal) begin
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        dig_valid_q <= 1'b1;
                        state_q     <= S_ADD;
                    end
                end
                S_ADD: begin
                    carry_q <= dig_cout;
                    acc_q   <= acc_d;
                    a_sr_q  <= a_sr_d;
                    b_sr_q  <= b_sr_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        // Publish the final shifted accumulator, including this digit
                        sum_q       <= acc_d;
                        cout_q      <= dig_cout;
                        err_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        dig_valid_q <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;
    assign dig_valid = dig_valid_q;
    assign dig_a     = dig_valid_q ? a_sr_q[3:0] : 4'd0;
    assign dig_b     = dig_valid_q ? b_sr_q[3:0] : 4'd0;
    assign dig_cin   = dig_valid_q & carry_q;

endmodule

// File: tb/tb_bcd_serial_add_ctl.sv
// tb/tb_bcd_serial_add_ctl.sv - directed scoreboard bench for bcd_serial_add_ctl
module tb_bcd_serial_add_ctl;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } result_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout, err, dig_valid, dig_cin;
    logic [W-1:0]  sum_out;
    logic [3:0]    dig_a, dig_b;
    logic [3:0]    dig_sum;
    logic          dig_cout;

    int            vectors = 0;
    int            miscompares = 0;
    result_t       sb[$];
    logic [3:0]    dig_log[$];
    int            valid_cycles = 0;

    bcd_serial_add_ctl #(.NDIGITS(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .cout      (cout),
        .err       (err),
        .dig_valid (dig_valid),
        .dig_a     (dig_a),
        .dig_b     (dig_b),
        .dig_cin   (dig_cin),
        .dig_sum   (dig_sum),
        .dig_cout  (dig_cout)
    );

    always #5 clk = ~clk;

    // Behavioural model of a correct external one-digit BCD adder
    always_comb begin
        logic [4:0] raw;
        raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, dig_cin};
        if (raw > 5'd9) begin
            dig_sum  = 4'(raw - 5'd10);
            dig_cout = 1'b1;
        end else begin
            dig_sum  = raw[3:0];
            dig_cout = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (dig_valid) begin
            dig_log.push_back(dig_a);
            valid_cycles++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the published result against the oldest scoreboard entry
    task automatic pop_check(input string tag);
        result_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum_out), 32'(e.sum));
            chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
            chk({tag, "_err"}, 32'(err), 32'(e.err));
        end
    endtask

    // Drive a one-cycle start; returns edges from the sampling edge to done and busy-cycle count
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input result_t exp, input bit poke_mid,
                          output int lat, output int busy_cnt);
        @(posedge clk); #1;
        a_in = a; b_in = b; cin = c; start = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            lat++;
            if (poke_mid && lat == 2) start = 1'b1;
            if (poke_mid && lat == 3) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 32'(lat), 32'hFFFF);
    endtask

    // Count done pulses over a quiet window with start low
    task automatic quiet_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        int lat, bc, nd, gap;
        result_t r;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_dig_valid", 32'(dig_valid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        quiet_dones(10, nd);
        chk("idle_dones", 32'(nd), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Nominal 1234 + 5678
        dig_log.delete();
        r = '{sum: 16'h6912, cout: 1'b0, err: 1'b0};
        run_op(16'h1234, 16'h5678, 1'b0, r, 1'b0, lat, bc);
        chk("nom_latency", 32'(lat), 32'd5);
        chk("nom_busy_cycles", 32'(bc), 32'd5);
        pop_check("nom");
        chk("nom_dig_count", 32'(dig_log.size()), 32'd4);
        if (dig_log.size() == 4) begin
            chk("nom_dig_a", {16'd0, dig_log[0], dig_log[1], dig_log[2], dig_log[3]}, 32'h4321);
        end
        @(posedge clk); #1;
        chk("nom_done_pulse", 32'(done), 32'd0);
        chk("nom_dig_a_idle", 32'(dig_a), 32'd0);

        // Carry ripple 9999 + 0000 + 1
        r = '{sum: 16'h0000, cout: 1'b1, err: 1'b0};
        run_op(16'h9999, 16'h0000, 1'b1, r, 1'b0, lat, bc);
        chk("rip_latency", 32'(lat), 32'd5);
        pop_check("rip");

        // Illegal operand digit
        valid_cycles = 0;
        r = '{sum: 16'h0000, cout: 1'b0, err: 1'b1};
        run_op(16'h12A4, 16'h0001, 1'b0, r, 1'b0, lat, bc);
        chk("ill_latency", 32'(lat), 32'd1);
        pop_check("ill");
        chk("ill_dig_valid", 32'(valid_cycles), 32'd0);

        // Start pulsed during ADD is ignored
        r = '{sum: 16'h0579, cout: 1'b0, err: 1'b0};
        run_op(16'h0123, 16'h0456, 1'b0, r, 1'b1, lat, bc);
        chk("ign_latency", 32'(lat), 32'd5);
        pop_check("ign");
        quiet_dones(12, nd);
        chk("ign_extra_done", 32'(nd), 32'd0);

        // Back-to-back with start held high
        @(posedge clk); #1;
        a_in = 16'h0005; b_in = 16'h0005; cin = 1'b0; start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            sb.push_back('{sum: 16'h0010, cout: 1'b0, err: 1'b0});
            gap = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                gap++;
                if (done) break;
            end
            if (op == 2) start = 1'b0;
            pop_check("b2b");
            if (op > 0) chk("b2b_period", 32'(gap), 32'd7);
        end
        quiet_dones(12, nd);
        chk("b2b_tail_done", 32'(nd), 32'd0);

        // Reset during the second ADD cycle
        @(posedge clk); #1;
        a_in = 16'h1234; b_in = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(sum_out), 32'd0);
        chk("mid_rst_flags", {28'd0, busy, done, dig_valid, cout}, 32'd0);
        chk("mid_rst_dig", {24'd0, dig_a, dig_b}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        quiet_dones(10, nd);
        chk("mid_rst_no_done", 32'(nd), 32'd0);
        r = '{sum: 16'h0002, cout: 1'b0, err: 1'b0};
        run_op(16'h0001, 16'h0001, 1'b0, r, 1'b0, lat, bc);
        chk("post_rst_latency", 32'(lat), 32'd5);
        pop_check("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
